// File: rtl/ibuf_loader.sv
// Loads one SRAM word per column buffer, then drives the column-0 shift enable for one 4x4 int8 tile.
// Latency: 14 cycles from accepted Start to the Done pulse, plus 1 cycle per stalled shift cycle.
// Backpressure: Stall pauses only the shift phase; Start while Busy is dropped, not queued.
module ibuf_loader #(
    parameter int NCOL   = 4,
    parameter int ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              Start,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic              Stall,
    output logic              MemCS,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [31:0]       MemRData,
    output logic [31:0]       IWord,
    output logic [NCOL-1:0]   WriteEN,
    output logic              ShiftEN,
    output logic              Busy,
    output logic              Done
);

    // Counter wide enough to index every column (at least 1 bit).
    localparam int CNT_W = (NCOL > 1) ? $clog2(NCOL) : 1;
    // Each word carries 4 bytes, so a column needs exactly 4 shifts.
    localparam logic [1:0] LAST_SHIFT = 2'd3;
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(NCOL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_FILL,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;       // column index in READ, settle count in DRAIN
    logic [1:0]        shcnt_q, shcnt_d;   // non-stalled shift cycles issued
    logic [ADDR_W-1:0] base_q, base_d;
    logic [NCOL-1:0]   wr_q;               // read strobe delayed to line up with MemRData
    logic [NCOL-1:0]   rd_sel;             // one-hot column being read this cycle

    // State, counters, captured base and the delayed per-column write strobe.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shcnt_q <= '0;
            base_q  <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shcnt_q <= shcnt_d;
            base_q  <= base_d;
            wr_q    <= rd_sel;
        end
    end

    // Next-state logic and all state-decoded outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shcnt_d = shcnt_q;
        base_d  = base_q;
        rd_sel  = '0;
        MemCS   = 1'b0;
        MemAddr = '0;
        ShiftEN = 1'b0;
        Done    = 1'b0;
        Busy    = (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    base_d  = BaseAddr;
                    cnt_d   = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                MemCS = 1'b1;
                // Wraps modulo 2^ADDR_W by construction of the adder width.
                MemAddr = base_q + ADDR_W'(cnt_q);
                rd_sel  = NCOL'(1) << cnt_q;
                if (cnt_q == LAST_COL) begin
                    cnt_d   = '0;
                    state_d = S_FILL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FILL: begin
                // Last read returns this cycle; shifting must wait for the write.
                shcnt_d = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                ShiftEN = !Stall;
                if (!Stall) begin
                    if (shcnt_q == LAST_SHIFT) begin
                        shcnt_d = '0;
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        shcnt_d = shcnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // Give the registered enable chain time to reach the last column.
                if (cnt_q == LAST_COL) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                Done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Shared word bus is only meaningful while a column is being written.
    always_comb begin
        WriteEN = wr_q;
        IWord   = (|wr_q) ? MemRData : 32'h0;
    end

endmodule

// File: doc/ibuf_loader.md
# ibuf_loader

Upstream controller for the four input column buffers of the MAC array. On `Start` it reads one 32-bit input word per column from input SRAM and writes each word into its column buffer. It then drives the shift-enable that ripples down the column chain so the array receives a skewed 4x4 int8 input tile. It reports completion once the last column has drained.

## Interface
- `NCOL`, 4: number of column buffers, equal to the number of words read per tile. Bytes per word are fixed at 4.
- `ADDR_W`, 10: SRAM word-address width.
- `CLK` input 1: single clock, rising edge.
- `RSTN` input 1: asynchronous, active-low reset.
- `Start` input 1: single-cycle request, sampled only in IDLE.
- `BaseAddr` input `ADDR_W`: address of the column-0 word. Captured when `Start` is accepted.
- `Stall` input 1: array back-pressure. Pauses the shift phase only.
- `MemCS` output 1: SRAM read strobe.
- `MemAddr` output `ADDR_W`: SRAM read address.
- `MemRData` input 32: SRAM read data, valid exactly 1 cycle after `MemCS`.
- `IWord` output 32: word bus shared by all column buffers. Byte [31:24] leaves the array first.
- `WriteEN` output `NCOL`: one-hot per-column write strobe.
- `ShiftEN` output 1: shift enable into column 0. Later columns receive it through the registered `ShiftEN_o` chain, 1 cycle per hop.
- `Busy` output 1: high from the cycle after `Start` is accepted through the DONE cycle.
- `Done` output 1: one-cycle completion pulse.

## Operation
- Reset values: all outputs 0, FSM in IDLE, all counters 0, captured address 0.
- FSM states:
  - IDLE: on `Start`, capture `BaseAddr` and go to READ.
  - READ: lasts `NCOL` cycles. Asserts `MemCS` with `MemAddr = base + k` for k = 0..NCOL-1, then goes to FILL.
  - FILL: lasts 1 cycle, to absorb the final read latency. Then goes to SHIFT.
  - SHIFT: `ShiftEN` = !`Stall`. Counts non-stalled cycles and moves to DRAIN after 4 of them.
  - DRAIN: lasts `NCOL` cycles, letting the ShiftEN ripple and OD registers settle. Then goes to DONE.
  - DONE: `Done` = 1 for one cycle, then back to IDLE.
- Write path:
  - `WriteEN[k]` is the read strobe for address base+k, delayed by 1 cycle. This aligns it with `MemRData`.
  - `IWord` = `MemRData` whenever any `WriteEN` bit is high, otherwise 0.
  - At most one `WriteEN` bit is high at a time.
- `WriteEN` and `ShiftEN` are never high in the same cycle. Column buffers give write priority, and this block guarantees the overlap never happens.
- Address arithmetic is modulo 2^`ADDR_W`. With base = 2^`ADDR_W`-1, column 1 reads address 0.
- `Stall` has no effect in READ, FILL, DRAIN or DONE.
- In SHIFT, a stalled cycle drives `ShiftEN` = 0 and holds the shift count. Columns downstream still complete their in-flight shifts through the chain.
- `Start` while `Busy` is ignored; it is not queued.
- `RSTN` low in any state forces the reset values immediately. No partial `Done` is produced.

## Timing
- `Start` accepted at cycle t, no stalls:
  - `MemCS` high t+1..t+4, addresses base..base+3.
  - `WriteEN` = 0001, 0010, 0100, 1000 at t+2..t+5, with `IWord` = the word read the previous cycle.
  - FILL at t+5, overlapping the last write.
  - `ShiftEN` high t+6..t+9.
  - DRAIN t+10..t+13.
  - `Done` at t+14; `Busy` high t+1..t+14.
- Total latency without stalls: 14 cycles from `Start` to `Done`. Each stalled SHIFT cycle adds 1.
- The earliest next `Start` is accepted at t+15.
- Column c sees `ShiftEN` over t+6+c..t+9+c. Column 3's last shift is at t+12; its OD register updates at t+13, before `Done`.

## Test plan
- Basic load: memory[0x10..0x13] = 0x01020304, 0x05060708, 0x090A0B0C, 0x0D0E0F10, base 0x10, Start at t.
  - `WriteEN` one-hot t+2..t+5 with matching `IWord`.
  - Column 0 OD sequence 01,02,03,04 then 00.
  - `Done` at t+14.
- Stall: same tile, `Stall` high at t+7 and t+8.
  - `ShiftEN` pattern 1,0,0,1,1,1 over t+6..t+11.
  - `Done` at t+16; no `WriteEN` during SHIFT.
- Wrap: base = 0x3FF, `ADDR_W` = 10 → `MemAddr` sequence 0x3FF, 0x000, 0x001, 0x002.
- Start while busy: second `Start` pulse at t+5 and another at t+14.
  - Both ignored; exactly one `Done`.
  - A new `Start` at t+15 begins a fresh READ at t+16.
- Reset mid-run: `RSTN` low at t+7 for 2 cycles.
  - All outputs 0 immediately; `Busy` 0; no `Done`.
  - After release, IDLE accepts `Start` normally.
- Back-to-back tiles: `Start` at t and again at t+15 with different bases → two `Done` pulses, at t+14 and t+29.
